// File: rtl/io_byte_writer_arb_pkg.sv
// Shared types and helpers for the byte-stream writer arbiter.
package io_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits, even for a single requester.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_byte_writer_arb_if.sv
// Requester-side and sink-side byte handshakes of the writer arbiter.
interface io_byte_writer_arb_if #(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic [7:0]           out_data;
  logic                 out_last;
  logic                 out_ready;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/io_byte_writer_arb_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module io_rr_pick
  import io_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] doubled;
  logic [IDX_W:0] pos;
  logic [IDX_W:0] sum;
  logic           found;

  assign doubled = {req, req};
  assign any     = |req;

  // Scan the doubled vector from ptr so the wrap-around needs no special case.
  always_comb begin
    found = 1'b0;
    pos   = '0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (!found && doubled[pos]) begin
        found = 1'b1;
        sum   = pos;
      end
    end
    if (sum >= (IDX_W+1)'(N)) begin
      sum = sum - (IDX_W+1)'(N);
    end
    idx   = sum[IDX_W-1:0];
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/io_byte_writer_arb.sv
// Per-message round-robin arbiter sharing one byte sink, with stall eviction.
module io_byte_writer_arb
  import io_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int IDLE_TIMEOUT = 64,
  parameter  int CNT_W        = 16,
  localparam int ID_W         = clog2_min1(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  io_byte_writer_arb_if.slave  bus,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic [CNT_W-1:0]     msg_len,
  output logic                 err_timeout,
  output logic [ID_W-1:0]      err_id
);

  arb_state_e         state, state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_after;
  logic [NUM_REQ-1:0] grant_oh;
  logic [15:0]        idle_cnt;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  logic               cur_valid;
  logic [7:0]         cur_data;
  logic               cur_last;

  logic               out_valid_c;
  logic [7:0]         out_data_c;
  logic               out_last_c;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               xfer;
  logic               evict;

  io_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign cur_valid = bus.req_valid[grant_id];
  assign cur_data  = bus.req_data[{grant_id, 3'b000} +: 8];
  assign cur_last  = bus.req_last[grant_id];
  assign ptr_after = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_last  = out_last_c;
  assign bus.req_ready = req_ready_c;
  assign busy          = (state == ARB_LOCKED);

  // Next-state decode and pass-through of the locked requester to the sink.
  always_comb begin
    state_nxt   = state;
    out_valid_c = 1'b0;
    out_data_c  = 8'h00;
    out_last_c  = 1'b0;
    req_ready_c = '0;
    xfer        = 1'b0;
    evict       = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_nxt = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        out_valid_c = cur_valid;
        out_data_c  = cur_data;
        out_last_c  = cur_last;
        req_ready_c = grant_oh & {NUM_REQ{bus.out_ready}};
        xfer        = cur_valid & bus.out_ready;
        if (xfer && cur_last) begin
          state_nxt = ARB_IDLE;
        end else if (!cur_valid && (idle_cnt == 16'(IDLE_TIMEOUT - 1))) begin
          evict     = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // State, grant, byte counter, stall counter and error pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      grant_oh    <= '0;
      msg_len     <= '0;
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
      err_id      <= '0;
    end else begin
      state       <= state_nxt;
      err_timeout <= evict;
      if (evict) begin
        err_id <= grant_id;
      end
      if (state == ARB_IDLE) begin
        if (pick_any) begin
          grant_id <= pick_idx;
          grant_oh <= pick_grant;
          msg_len  <= '0;
          idle_cnt <= '0;
        end
      end else begin
        if (xfer) begin
          idle_cnt <= '0;
          if (msg_len != '1) begin
            msg_len <= msg_len + CNT_W'(1);
          end
        end else if (!cur_valid) begin
          idle_cnt <= idle_cnt + 16'd1;
        end
        if ((xfer && cur_last) || evict) begin
          ptr <= ptr_after;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_byte_writer_arb.sv
// Directed bench for io_byte_writer_arb: vector table plus multi-cycle sequences.
module tb_io_byte_writer_arb;

  localparam int NR = 4;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] grant_id;
  logic [3:0] msg_len;
  logic       err_timeout;
  logic [1:0] err_id;

  int total = 0;
  int bad   = 0;

  io_byte_writer_arb_if #(.NUM_REQ(NR)) bus ();

  io_byte_writer_arb #(
    .NUM_REQ      (NR),
    .IDLE_TIMEOUT (4),
    .CNT_W        (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .grant_id    (grant_id),
    .msg_len     (msg_len),
    .err_timeout (err_timeout),
    .err_id      (err_id)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "[TB] time limit");
  end

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ol;
    logic [3:0]  e_rr;
    logic        e_busy;
    logic [1:0]  e_gid;
    logic [3:0]  e_len;
  } vec_t;

  vec_t tbl[$];

  int         msgCnt[NR];
  logic [7:0] msgBase[NR];
  int         pos[NR];
  logic [7:0] expData[$];
  int         expGrant[$];
  bit         expLast[$];
  bit         readyPat[$];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                              input logic [3:0] l, input logic rdy, input logic ov,
                              input logic [7:0] od, input logic ol, input logic [3:0] rr,
                              input logic b, input logic [1:0] g, input logic [3:0] len);
    vec_t x;
    x.rst_n = r;  x.valid = v;  x.data = d;  x.last = l;  x.rdy = rdy;
    x.e_ov = ov;  x.e_od = od;  x.e_ol = ol; x.e_rr = rr; x.e_busy = b;
    x.e_gid = g;  x.e_len = len;
    return x;
  endfunction

  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] d,
                               input logic [3:0] l, input logic rdy);
    @(posedge clk);
    #1;
    rst_n         = r;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    bus.out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic queueMsg(input int id, input logic [7:0] base, input int cnt);
    msgCnt[id]  = cnt;
    msgBase[id] = base;
    pos[id]     = 0;
  endtask

  task automatic expectMsg(input int id, input logic [7:0] base, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      expData.push_back(base + 8'(k));
      expGrant.push_back(id);
      expLast.push_back(k == cnt - 1);
    end
  endtask

  // Drives the queued messages, checks every sink transfer against the expected order.
  task automatic runSession(input string tag, input int expLen);
    int          cyc;
    bit          prevLast;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        rdy;
    cyc      = 0;
    prevLast = 0;
    while (expData.size() > 0 && cyc < 600) begin
      cyc++;
      v = '0;
      d = '0;
      l = '0;
      for (int i = 0; i < NR; i++) begin
        if (pos[i] < msgCnt[i]) begin
          v[i]       = 1'b1;
          d[8*i +: 8] = msgBase[i] + 8'(pos[i]);
          l[i]       = (pos[i] == msgCnt[i] - 1);
        end
      end
      rdy = (readyPat.size() > 0) ? readyPat.pop_front() : 1'b1;
      applyStimulus(1'b1, v, d, l, rdy);
      @(negedge clk);
      checkOutput({tag, "_no_err"}, 32'(err_timeout), 32'd0);
      if (prevLast) begin
        checkOutput({tag, "_bubble"}, {30'd0, busy, bus.out_valid}, 32'd0);
        prevLast = 0;
      end
      if (busy) begin
        checkOutput({tag, "_req_ready"}, 32'(bus.req_ready),
                    rdy ? (32'd1 << expGrant[0]) : 32'd0);
      end else begin
        checkOutput({tag, "_req_ready_idle"}, 32'(bus.req_ready), 32'd0);
      end
      if (bus.out_valid && rdy) begin
        checkOutput({tag, "_data"}, 32'(bus.out_data), 32'(expData[0]));
        checkOutput({tag, "_grant"}, 32'(grant_id), 32'(expGrant[0]));
        checkOutput({tag, "_last"}, 32'(bus.out_last), 32'(expLast[0]));
        prevLast = bus.out_last;
        void'(expData.pop_front());
        void'(expGrant.pop_front());
        void'(expLast.pop_front());
      end
      for (int i = 0; i < NR; i++) begin
        if (v[i] && bus.req_ready[i]) pos[i]++;
      end
    end
    total++;
    if (expData.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_budget: bytes_left=%0d required=0", tag, expData.size());
      expData.delete();
      expGrant.delete();
      expLast.delete();
    end
    for (int i = 0; i < NR; i++) begin
      msgCnt[i] = 0;
      pos[i]    = 0;
    end
    readyPat.delete();
    applyStimulus(1'b1, 4'b0, 32'd0, 4'b0, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_end_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_end_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_end_len"}, 32'(msg_len), 32'(expLen));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      msgCnt[i]  = 0;
      msgBase[i] = 8'h00;
      pos[i]     = 0;
    end
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("reset_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
    checkOutput("reset_msg_len", 32'(msg_len), 32'd0);
    checkOutput("reset_err", {30'd0, err_timeout, 1'b0} | 32'(err_id), 32'd0);

    // Single requester 2 message, then reset mid-message and a clean req3 message.
    tbl.push_back(mk(1, 4'b0100, 32'h007B0000, 4'b0000, 1, 0, 8'h00, 0, 4'b0000, 0, 2'd0, 4'd0));
    tbl.push_back(mk(1, 4'b0100, 32'h007B0000, 4'b0000, 1, 1, 8'h7B, 0, 4'b0100, 1, 2'd2, 4'd0));
    tbl.push_back(mk(1, 4'b0100, 32'h00220000, 4'b0000, 1, 1, 8'h22, 0, 4'b0100, 1, 2'd2, 4'd1));
    tbl.push_back(mk(1, 4'b0100, 32'h007D0000, 4'b0100, 1, 1, 8'h7D, 1, 4'b0100, 1, 2'd2, 4'd2));
    tbl.push_back(mk(1, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 0, 4'b0000, 0, 2'd2, 4'd3));
    tbl.push_back(mk(1, 4'b0010, 32'h0000A100, 4'b0000, 1, 0, 8'h00, 0, 4'b0000, 0, 2'd2, 4'd3));
    tbl.push_back(mk(1, 4'b0010, 32'h0000A100, 4'b0000, 1, 1, 8'hA1, 0, 4'b0010, 1, 2'd1, 4'd0));
    tbl.push_back(mk(1, 4'b0010, 32'h0000A200, 4'b0000, 1, 1, 8'hA2, 0, 4'b0010, 1, 2'd1, 4'd1));
    tbl.push_back(mk(0, 4'b0010, 32'h0000A300, 4'b0000, 1, 1, 8'hA3, 0, 4'b0010, 1, 2'd1, 4'd2));
    tbl.push_back(mk(1, 4'b1000, 32'hC1000000, 4'b0000, 1, 0, 8'h00, 0, 4'b0000, 0, 2'd0, 4'd0));
    tbl.push_back(mk(1, 4'b1000, 32'hC1000000, 4'b0000, 1, 1, 8'hC1, 0, 4'b1000, 1, 2'd3, 4'd0));
    tbl.push_back(mk(1, 4'b1000, 32'hC2000000, 4'b1000, 1, 1, 8'hC2, 1, 4'b1000, 1, 2'd3, 4'd1));
    tbl.push_back(mk(1, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 0, 4'b0000, 0, 2'd3, 4'd2));

    for (int r = 0; r < tbl.size(); r++) begin
      applyStimulus(tbl[r].rst_n, tbl[r].valid, tbl[r].data, tbl[r].last, tbl[r].rdy);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_out_valid", r), 32'(bus.out_valid), 32'(tbl[r].e_ov));
      checkOutput($sformatf("vec%0d_out_data", r), 32'(bus.out_data), 32'(tbl[r].e_od));
      checkOutput($sformatf("vec%0d_out_last", r), 32'(bus.out_last), 32'(tbl[r].e_ol));
      checkOutput($sformatf("vec%0d_req_ready", r), 32'(bus.req_ready), 32'(tbl[r].e_rr));
      checkOutput($sformatf("vec%0d_busy", r), 32'(busy), 32'(tbl[r].e_busy));
      checkOutput($sformatf("vec%0d_grant_id", r), 32'(grant_id), 32'(tbl[r].e_gid));
      checkOutput($sformatf("vec%0d_msg_len", r), 32'(msg_len), 32'(tbl[r].e_len));
      checkOutput($sformatf("vec%0d_err", r), 32'(err_timeout), 32'd0);
    end

    // Contention: 0, 1, 3 in order, then 0 again ahead of 2.
    queueMsg(0, 8'h01, 2);
    queueMsg(1, 8'h11, 2);
    queueMsg(3, 8'h31, 2);
    expectMsg(0, 8'h01, 2);
    expectMsg(1, 8'h11, 2);
    expectMsg(3, 8'h31, 2);
    runSession("contention", 2);
    queueMsg(0, 8'h05, 1);
    queueMsg(2, 8'h25, 2);
    expectMsg(0, 8'h05, 1);
    expectMsg(2, 8'h25, 2);
    runSession("rerequest", 2);

    // Timeout: req0 stalls after one byte, req1 waits with a single-byte message.
    applyStimulus(1'b1, 4'b0011, 32'h0000F0E0, 4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("to_first_bubble", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, 4'b0011, 32'h0000F0E0, 4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("to_byte_data", 32'(bus.out_data), 32'hE0);
    checkOutput("to_byte_grant", 32'(grant_id), 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 4'b0010, 32'h0000F000, 4'b0010, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("to_stall%0d_busy", k), 32'(busy), 32'd1);
      checkOutput($sformatf("to_stall%0d_err", k), 32'(err_timeout), 32'd0);
    end
    applyStimulus(1'b1, 4'b0010, 32'h0000F000, 4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("to_pulse", 32'(err_timeout), 32'd1);
    checkOutput("to_err_id", 32'(err_id), 32'd0);
    checkOutput("to_busy_fall", 32'(busy), 32'd0);
    checkOutput("to_no_last", 32'(bus.out_last), 32'd0);
    applyStimulus(1'b1, 4'b0010, 32'h0000F000, 4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("to_pulse_end", 32'(err_timeout), 32'd0);
    checkOutput("to_next_grant", 32'(grant_id), 32'd1);
    checkOutput("to_next_data", {22'd0, bus.out_valid, bus.out_last, bus.out_data}, 32'h3F0);
    applyStimulus(1'b1, 4'b0000, 32'd0, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("to_next_len", 32'(msg_len), 32'd1);
    checkOutput("to_next_busy", 32'(busy), 32'd0);

    // Backpressure on a 4-byte message from req1, including a 100-cycle stall.
    queueMsg(1, 8'h41, 4);
    expectMsg(1, 8'h41, 4);
    readyPat.push_back(1'b1);
    readyPat.push_back(1'b1);
    readyPat.push_back(1'b0);
    readyPat.push_back(1'b0);
    readyPat.push_back(1'b1);
    for (int k = 0; k < 100; k++) readyPat.push_back(1'b0);
    runSession("backpressure", 4);

    // Byte counter saturates at 15 while all 20 bytes still pass.
    queueMsg(2, 8'h60, 20);
    expectMsg(2, 8'h60, 20);
    runSession("saturate", 15);

    // Reset returns the round-robin pointer to requester 0.
    applyStimulus(1'b0, 4'b0000, 32'd0, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0000, 32'd0, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("rst2_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst2_msg_len", 32'(msg_len), 32'd0);
    queueMsg(2, 8'h70, 1);
    queueMsg(3, 8'h80, 1);
    expectMsg(2, 8'h70, 1);
    expectMsg(3, 8'h80, 1);
    runSession("ptr_reset", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
